// File: rtl/adc_frame_fifo_pkg.sv
// Shared definitions for adc_frame_fifo: register offsets, CTRL/STATUS bit
// positions and the left/right pairing state encoding.
package adc_frame_fifo_pkg;

    localparam int OFF_CTRL    = 'h00;
    localparam int OFF_THRESH  = 'h04;
    localparam int OFF_STATUS  = 'h08;
    localparam int OFF_DATA_L  = 'h0C;
    localparam int OFF_DATA_R  = 'h10;
    localparam int OFF_OVF_CNT = 'h14;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_CLR_BIT  = 1;

    localparam int ST_EMPTY_BIT  = 8;
    localparam int ST_FULL_BIT   = 9;
    localparam int ST_OVF_BIT    = 10;
    localparam int ST_DESYNC_BIT = 11;

    typedef enum logic {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } pair_state_t;

endpackage

// File: rtl/adc_frame_fifo_if.sv
// Sample stream from the SPI ADC front end plus the simple CPU bus
// (wr/wrAddr/wrData, rd/rdAddr/rdData) seen by adc_frame_fifo.
interface adc_frame_fifo_if #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 32
);
    logic                      sample_valid;
    logic [SPI_DATA_WIDTH-1:0] sample_data;
    logic                      sample_chan;
    logic                      wr;
    logic [ADDR_WIDTH-1:0]     wrAddr;
    logic [DATA_WIDTH-1:0]     wrData;
    logic                      rd;
    logic [ADDR_WIDTH-1:0]     rdAddr;
    logic [DATA_WIDTH-1:0]     rdData;

    modport master (
        output sample_valid, sample_data, sample_chan,
        output wr, wrAddr, wrData, rd, rdAddr,
        input  rdData
    );

    modport slave (
        input  sample_valid, sample_data, sample_chan,
        input  wr, wrAddr, wrData, rd, rdAddr,
        output rdData
    );
endinterface

// File: rtl/sync_frame_fifo.sv
// Single-clock frame FIFO: storage, wrapping pointers, level and full/empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_frame_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 16,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (PW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and level alone define
    // which entries are valid, and a reset on the array would defeat RAM inference.
    always_ff @(posedge S_AXI_ACLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_fifo.sv
// Pairs left/right ADC samples into stereo frames, buffers them and exposes
// them over the simple bus; ADC_FRAME_FIFO_OVF_CNT_EN adds a dropped-frame counter.
module adc_frame_fifo
    import adc_frame_fifo_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 14,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int SPI_DATA_WIDTH     = 32,
    parameter int DEPTH              = 16,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 14'h1800
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    adc_frame_fifo_if.slave    bus,
    output logic               irq
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = SPI_DATA_WIDTH;
    localparam int FW = 2 * SW;
    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic [AW-1:0] A_CTRL    = AW'(BASE_ADDR + OFF_CTRL);
    localparam logic [AW-1:0] A_THRESH  = AW'(BASE_ADDR + OFF_THRESH);
    localparam logic [AW-1:0] A_STATUS  = AW'(BASE_ADDR + OFF_STATUS);
    localparam logic [AW-1:0] A_DATA_L  = AW'(BASE_ADDR + OFF_DATA_L);
    localparam logic [AW-1:0] A_DATA_R  = AW'(BASE_ADDR + OFF_DATA_R);
    localparam logic [AW-1:0] A_OVF_CNT = AW'(BASE_ADDR + OFF_OVF_CNT);

    logic          enable;
    logic [LW-1:0] thresh;
    logic          ovf;
    logic          desync;
    pair_state_t   state;
    logic [SW-1:0] left_q;

    logic [FW-1:0] head;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;

    logic wr_ctrl, wr_thresh, wr_status;
    logic clear, smp, push_req, pop_req, drop, desync_evt;
    logic unused_wr_bits;

    assign wr_ctrl   = bus.wr && (bus.wrAddr == A_CTRL);
    assign wr_thresh = bus.wr && (bus.wrAddr == A_THRESH);
    assign wr_status = bus.wr && (bus.wrAddr == A_STATUS);
    assign unused_wr_bits = ^bus.wrData;

    // clear acts on the write edge itself, so it never holds state and reads back 0
    assign clear      = wr_ctrl && bus.wrData[CTRL_CLR_BIT];
    assign smp        = enable && bus.sample_valid;
    assign push_req   = smp && (state == WAIT_R) && bus.sample_chan && !clear;
    assign pop_req    = bus.rd && (bus.rdAddr == A_DATA_R) && !empty && !clear;
    assign drop       = push_req && full && !pop_req;
    assign desync_evt = smp && (((state == WAIT_L) &&  bus.sample_chan) ||
                                ((state == WAIT_R) && !bus.sample_chan));

    sync_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .push          (push_req),
        .pop           (pop_req),
        .flush         (clear),
        .din           ({left_q, bus.sample_data}),
        .dout          (head),
        .level         (level),
        .full          (full),
        .empty         (empty)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || clear || !enable) begin
            state  <= WAIT_L;
            left_q <= '0;
        end else if (bus.sample_valid) begin
            case (state)
                WAIT_L: if (!bus.sample_chan) begin
                    left_q <= bus.sample_data;
                    state  <= WAIT_R;
                end
                WAIT_R: if (bus.sample_chan) state  <= WAIT_L;
                        else                 left_q <= bus.sample_data;
                default: state <= WAIT_L;
            endcase
        end
    end

    // Sticky flags: clear beats a set event, a set event beats a W1C write.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            enable <= 1'b0;
            thresh <= '0;
            ovf    <= 1'b0;
            desync <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl)   enable <= bus.wrData[CTRL_EN_BIT];
            if (wr_thresh) thresh <= bus.wrData[LW-1:0];

            if (clear)                                    ovf <= 1'b0;
            else if (drop)                                ovf <= 1'b1;
            else if (wr_status && bus.wrData[ST_OVF_BIT]) ovf <= 1'b0;

            if (clear)                                       desync <= 1'b0;
            else if (desync_evt)                             desync <= 1'b1;
            else if (wr_status && bus.wrData[ST_DESYNC_BIT]) desync <= 1'b0;

            irq <= enable && (thresh != '0) && (level >= thresh);
        end
    end

`ifdef ADC_FRAME_FIFO_OVF_CNT_EN
    logic [15:0] ovf_cnt;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN || clear)       ovf_cnt <= '0;
        else if (drop && ovf_cnt != '1)    ovf_cnt <= ovf_cnt + 1'b1;
    end
`endif

    // NOTE: the read mux assigns a default first so no path infers a latch.
    always_comb begin
        bus.rdData = '0;
        case (bus.rdAddr)
            A_CTRL:   bus.rdData = DW'(enable);
            A_THRESH: bus.rdData = DW'(thresh);
            A_STATUS: begin
                bus.rdData[7:0]           = 8'(level);
                bus.rdData[ST_EMPTY_BIT]  = empty;
                bus.rdData[ST_FULL_BIT]   = full;
                bus.rdData[ST_OVF_BIT]    = ovf;
                bus.rdData[ST_DESYNC_BIT] = desync;
            end
            A_DATA_L: if (!empty) bus.rdData = DW'(head[FW-1 -: SW]);
            A_DATA_R: if (!empty) bus.rdData = DW'(head[SW-1:0]);
`ifdef ADC_FRAME_FIFO_OVF_CNT_EN
            A_OVF_CNT: bus.rdData = DW'(ovf_cnt);
`endif
            default: bus.rdData = '0;
        endcase
    end

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Self-checking bench for adc_frame_fifo: directed scenarios plus randomized
// traffic compared against a queue-based frame model.
module tb_adc_frame_fifo;

    localparam int          DEPTH    = 16;
    localparam logic [13:0] BASE     = 14'h1800;
    localparam logic [13:0] A_CTRL   = BASE + 14'h00;
    localparam logic [13:0] A_THR    = BASE + 14'h04;
    localparam logic [13:0] A_ST     = BASE + 14'h08;
    localparam logic [13:0] A_DL     = BASE + 14'h0C;
    localparam logic [13:0] A_DR     = BASE + 14'h10;
    localparam logic [13:0] A_CNT    = BASE + 14'h14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    always #5 clk = ~clk;

    adc_frame_fifo_if bus ();

    adc_frame_fifo dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus),
        .irq           (irq)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of {left,right} frames plus flags.
    logic [63:0] q[$];
    bit          m_en, m_ovf, m_ds, m_have_l, m_irq;
    logic [31:0] m_left;
    logic [4:0]  m_thr;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 0; m_ovf = 0; m_ds = 0; m_have_l = 0; m_irq = 0;
        m_left = 0; m_thr = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [13:0] a);
        logic [31:0] v = 32'h0;
        int n = q.size();
        if (a == A_CTRL)     v = {31'b0, m_en};
        else if (a == A_THR) v = {27'b0, m_thr};
        else if (a == A_ST)  v = {20'b0, m_ds, m_ovf, n == DEPTH, n == 0, 8'(n)};
        else if (a == A_DL)  v = (n > 0) ? q[0][63:32] : 32'h0;
        else if (a == A_DR)  v = (n > 0) ? q[0][31:0]  : 32'h0;
`ifdef ADC_FRAME_FIFO_OVF_CNT_EN
        else if (a == A_CNT) v = 32'(m_cnt);
`endif
        return v;
    endfunction

    task automatic model_step(input bit sv, input logic [31:0] sd, input bit sc,
                              input bit w, input logic [13:0] wa, input logic [31:0] wd,
                              input bit r, input logic [13:0] ra);
        bit clr = w && (wa == A_CTRL) && wd[1];
        bit pop = r && (ra == A_DR) && (q.size() > 0) && !clr;
        bit push = 0;
        bit dsy = 0;
        logic [63:0] fr = 64'h0;
        m_irq = m_en && (m_thr != 0) && (q.size() >= int'(m_thr));
        if (!m_en) m_have_l = 0;
        else if (sv) begin
            if (!m_have_l) begin
                if (!sc) begin m_have_l = 1; m_left = sd; end
                else dsy = 1;
            end else begin
                if (sc) begin push = 1; fr = {m_left, sd}; m_have_l = 0; end
                else begin m_left = sd; dsy = 1; end
            end
        end
        if (w && wa == A_ST) begin
            if (wd[10]) m_ovf = 0;
            if (wd[11]) m_ds = 0;
        end
        if (dsy) m_ds = 1;
        if (clr) begin
            q.delete(); m_ovf = 0; m_ds = 0; m_have_l = 0; m_cnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(fr);
                else begin m_ovf = 1; if (m_cnt < 65535) m_cnt++; end
            end
        end
        if (w && wa == A_CTRL) m_en = wd[0];
        if (w && wa == A_THR)  m_thr = wd[4:0];
    endtask

    // One clock: drive at negedge, check any read before the edge, update model, check irq.
    task automatic cycle(input string tag, input bit sv, input logic [31:0] sd, input bit sc,
                         input bit w, input logic [13:0] wa, input logic [31:0] wd,
                         input bit r, input logic [13:0] ra, output logic [31:0] rv);
        @(negedge clk);
        bus.sample_valid = sv; bus.sample_data = sd; bus.sample_chan = sc;
        bus.wr = w; bus.wrAddr = wa; bus.wrData = wd;
        bus.rd = r; bus.rdAddr = ra;
        #1 rv = bus.rdData;
        if (r) check(tag, rv, model_read(ra));
        @(posedge clk);
        model_step(sv, sd, sc, w, wa, wd, r, ra);
        #1 check("irq", {31'b0, irq}, {31'b0, m_irq});
        bus.sample_valid = 0; bus.wr = 0; bus.rd = 0;
    endtask

    task automatic idle();
        logic [31:0] d;
        cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0, d);
    endtask

    task automatic wr_reg(input logic [13:0] a, input logic [31:0] v);
        logic [31:0] d;
        cycle("wr", 0, 0, 0, 1, a, v, 0, 0, d);
    endtask

    task automatic rd_reg(input string tag, input logic [13:0] a, output logic [31:0] v);
        cycle(tag, 0, 0, 0, 0, 0, 0, 1, a, v);
    endtask

    task automatic smp(input bit ch, input logic [31:0] v);
        logic [31:0] d;
        cycle("smp", 1, v, ch, 0, 0, 0, 0, 0, d);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        bus.sample_valid = 0; bus.wr = 0; bus.rd = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1 check("irq_in_reset", {31'b0, irq}, 32'h0);
        @(negedge clk);
        rst_n = 1;
    endtask

    logic [13:0] rd_addrs [7];
    logic [31:0] v;

    initial begin
        bus.sample_valid = 0; bus.sample_data = 0; bus.sample_chan = 0;
        bus.wr = 0; bus.wrAddr = 0; bus.wrData = 0; bus.rd = 0; bus.rdAddr = 0;
        rd_addrs = '{A_CTRL, A_THR, A_ST, A_DL, A_DR, A_CNT, BASE + 14'h18};
        model_reset();
        apply_reset();

        // Reset state
        rd_reg("ctrl_rst", A_CTRL, v);   check("ctrl_rst_k", v, 32'h0);
        rd_reg("thr_rst", A_THR, v);     check("thr_rst_k", v, 32'h0);
        rd_reg("st_rst", A_ST, v);       check("st_rst_k", v, 32'h100);

        // Single frame round trip
        wr_reg(A_CTRL, 32'h1);
        smp(0, 32'h11);
        smp(1, 32'h22);
        rd_reg("st_one", A_ST, v);       check("st_one_k", v, 32'h001);
        rd_reg("dl_one", A_DL, v);       check("dl_one_k", v, 32'h11);
        rd_reg("dr_one", A_DR, v);       check("dr_one_k", v, 32'h22);
        rd_reg("st_pop", A_ST, v);       check("st_pop_k", v, 32'h100);
        rd_reg("dr_empty", A_DR, v);     check("dr_empty_k", v, 32'h0);

        // Overflow: 17 pairs into 16 slots
        for (int i = 0; i < 17; i++) begin
            smp(0, 32'h1000 + i);
            smp(1, 32'h2000 + i);
        end
        rd_reg("st_full", A_ST, v);      check("st_full_k", v, 32'h610);
        rd_reg("cnt_full", A_CNT, v);
`ifdef ADC_FRAME_FIFO_OVF_CNT_EN
        check("cnt_full_k", v, 32'h1);
`else
        check("cnt_full_k", v, 32'h0);
`endif
        wr_reg(A_ST, 32'h400);
        rd_reg("st_w1c", A_ST, v);       check("st_w1c_k", v, 32'h210);

        // Full FIFO: pop and push on the same edge
        smp(0, 32'hAAAA);
        cycle("dr_pp", 1, 32'hBBBB, 1, 0, 0, 0, 1, A_DR, v);
        check("dr_pp_k", v, 32'h2000);
        rd_reg("st_pp", A_ST, v);        check("st_pp_k", v, 32'h210);
        rd_reg("dl_pp", A_DL, v);        check("dl_pp_k", v, 32'h1001);

        // Clear
        wr_reg(A_CTRL, 32'h3);
        rd_reg("st_clr", A_ST, v);       check("st_clr_k", v, 32'h100);
        rd_reg("ctrl_clr", A_CTRL, v);   check("ctrl_clr_k", v, 32'h1);

        // Desync: R, L, L, R
        smp(1, 32'h99);
        smp(0, 32'hA);
        smp(0, 32'hB);
        smp(1, 32'hC);
        rd_reg("st_ds", A_ST, v);        check("st_ds_k", v, 32'h801);
        rd_reg("dl_ds", A_DL, v);        check("dl_ds_k", v, 32'hB);
        rd_reg("dr_ds", A_DR, v);        check("dr_ds_k", v, 32'hC);
        wr_reg(A_ST, 32'h800);
        rd_reg("st_ds_clr", A_ST, v);    check("st_ds_clr_k", v, 32'h100);

        // Threshold irq
        wr_reg(A_THR, 32'h4);
        for (int i = 0; i < 4; i++) begin
            smp(0, 32'h300 + i);
            smp(1, 32'h400 + i);
        end
        check("irq_lag", {31'b0, irq}, 32'h0);
        idle();
        check("irq_rise", {31'b0, irq}, 32'h1);
        rd_reg("dr_thr", A_DR, v);
        check("irq_hold", {31'b0, irq}, 32'h1);
        idle();
        check("irq_fall", {31'b0, irq}, 32'h0);

        // Reset while waiting for a right sample
        smp(0, 32'h55);
        apply_reset();
        rd_reg("st_mid", A_ST, v);       check("st_mid_k", v, 32'h100);
        check("irq_mid", {31'b0, irq}, 32'h0);
        wr_reg(A_CTRL, 32'h1);
        smp(1, 32'h66);
        rd_reg("st_mid_ds", A_ST, v);    check("st_mid_ds_k", v, 32'h900);

        // Randomized traffic
        wr_reg(A_CTRL, 32'h3);
        for (int i = 0; i < 800; i++) begin
            bit          sv = 1'($urandom_range(0, 1));
            bit          sc = 1'($urandom_range(0, 1));
            logic [31:0] sd = $urandom;
            int          op = $urandom_range(0, 15);
            bit          w = 0, r = 0;
            logic [13:0] wa = 0, ra = 0;
            logic [31:0] wd = 0;
            if (op <= 5) begin
                r = 1; ra = rd_addrs[$urandom_range(0, 6)];
            end else if (op <= 8) begin
                r = 1; ra = A_DR;
            end else if (op == 9) begin
                w = 1; wa = A_ST; wd = 32'($urandom_range(0, 3)) << 10;
            end else if (op == 10) begin
                w = 1; wa = A_THR; wd = 32'($urandom_range(0, 8));
            end else if (op == 11) begin
                w = 1; wa = A_CTRL;
                wd = {30'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0)};
            end
            cycle("rnd_rd", sv, sd, sc, w, wa, wd, r, ra, v);
        end
        rd_reg("st_end", A_ST, v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
